axil_reg_master: RTL
====================

# axil_reg_master

AXI-Lite initiator that turns single register-access commands into AXI-Lite write or read transactions on the pixel generator's `s_axi_lite_*` slave port. It replaces bench-style manual address/data/response pulsing with a protocol-correct master. A controller or sequencer upstream issues one command at a time and receives one response per command.

## Interface
Parameters:
- ADDR_WIDTH, 8, AXI-Lite address width (byte address)
- DATA_WIDTH, 32, AXI-Lite data width

Ports:
- m_axi_lite_aclk  in  1  single clock for all logic
- axi_resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted on valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 after a write)
- rsp_resp  out  2  captured BRESP/RRESP
- rsp_err  out  1  rsp_resp != 2'b00
- m_axi_lite_awaddr  out  ADDR_WIDTH ; m_axi_lite_awvalid  out  1 ; m_axi_lite_awready  in  1
- m_axi_lite_wdata  out  DATA_WIDTH ; m_axi_lite_wvalid  out  1 ; m_axi_lite_wready  in  1
- m_axi_lite_bresp  in  2 ; m_axi_lite_bvalid  in  1 ; m_axi_lite_bready  out  1
- m_axi_lite_araddr  out  ADDR_WIDTH ; m_axi_lite_arvalid  out  1 ; m_axi_lite_arready  in  1
- m_axi_lite_rdata  in  DATA_WIDTH ; m_axi_lite_rresp  in  2 ; m_axi_lite_rvalid  in  1 ; m_axi_lite_rready  out  1

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register addr/wdata/write; go WR_AW_W (write) or RD_AR (read).
- WR_AW_W: awvalid and wvalid both asserted on entry. Each channel independent: awvalid clears the cycle after its awready handshake, wvalid the cycle after wready. Either order or same cycle legal. When both channels have completed -> WR_B.
- WR_B: bready=1. On bvalid: capture bresp, rsp_rdata<=0 -> RESP.
- RD_AR: arvalid=1 until arready handshake -> RD_R.
- RD_R: rready=1. On rvalid: capture rdata and rresp -> RESP.
- RESP: rsp_valid=1, data/resp stable. On rsp_ready -> IDLE.
- awaddr/araddr/wdata driven from registered command; stable while corresponding valid is high. Valid never drops before its ready (AXI rule).
- bvalid/rvalid outside WR_B/RD_R ignored (bready/rready low).
- Only one transaction outstanding; no pipelining.

## Timing
- Reset (async assert, sync release): state IDLE; cmd_ready=1; all *valid, bready, rready, rsp_valid, rsp_err = 0; rsp_rdata, rsp_resp, addr/data outputs = 0.
- Reset mid-transaction: all AXI valids/readies drop immediately; pending command and response discarded.
- All outputs registered except cmd_ready (decoded from state).
- Cycle 0 command handshake; cycle 1 awvalid/wvalid (or arvalid) high.
- Min write latency (ready and bvalid already high): awvalid/wvalid cycle 1, bready cycle 2, rsp_valid cycle 3.
- Min read latency: arvalid cycle 1, rready cycle 2, rsp_valid cycle 3.
- Slave stalls extend the respective state indefinitely; no timeout.
- rsp_valid held with stable data while rsp_ready low; next cmd_ready one cycle after rsp handshake.

## Test plan
- Write addr 0x04 data 0x11111111, slave readies high -> awaddr=0x04, wdata=0x11111111 on same cycle; rsp_valid at cycle 3, rsp_resp=0, rsp_err=0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid clears after 1 cycle, awvalid held 4 cycles with awaddr stable; bready only after both done.
- Read addr 0x1C, slave returns 0x77777777 after rvalid delay 5 -> rready held, rsp_rdata=0x77777777, rsp_resp=0.
- Slave bresp=2'b10 -> rsp_resp=2'b10, rsp_err=1.
- rsp_ready held low 4 cycles -> rsp_valid and rsp_rdata stable, cmd_ready=0, new cmd_valid not accepted.
- Write/read-back loop over 8 registers (addr i*4, data i*0x11111111) against pixel generator slave -> each read returns written value; axi_resetn pulsed low during WR_B -> all valids/readies 0 same cycle, cmd_ready=1.

Source files
------------

// File: rtl/axil_reg_master.sv
// axil_reg_master: single-command AXI-Lite initiator.
// Accepts one register read or write command at a time, runs the matching
// AXI-Lite transaction and holds the captured response until it is consumed.
// Every AXI and response output is registered. cmd_ready is decoded from the state.
module axil_reg_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  m_axi_lite_aclk,
    input  logic                  axi_resetn,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_err,
    // AXI-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                  m_axi_lite_awvalid,
    input  logic                  m_axi_lite_awready,
    output logic [DATA_WIDTH-1:0] m_axi_lite_wdata,
    output logic                  m_axi_lite_wvalid,
    input  logic                  m_axi_lite_wready,
    input  logic [1:0]            m_axi_lite_bresp,
    input  logic                  m_axi_lite_bvalid,
    output logic                  m_axi_lite_bready,
    // AXI-Lite read address / data
    output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                  m_axi_lite_arvalid,
    input  logic                  m_axi_lite_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_lite_rdata,
    input  logic [1:0]            m_axi_lite_rresp,
    input  logic                  m_axi_lite_rvalid,
    output logic                  m_axi_lite_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_s;

    logic                    accept_s;
    logic                    aw_hs_s;
    logic                    w_hs_s;
    logic                    ar_hs_s;
    logic                    b_hs_s;
    logic                    r_hs_s;
    logic                    wr_done_s;

    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [ADDR_WIDTH-1:0]   araddr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic                    arvalid_r;
    logic                    bready_r;
    logic                    rready_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]              rsp_resp_r;
    logic                    rsp_err_r;

    // Handshake decode; a write channel counts as done once its valid has dropped
    // or is completing this cycle, so AW and W may finish in any order.
    always_comb begin
        accept_s  = (state_r == IDLE) && cmd_valid;
        aw_hs_s   = awvalid_r && m_axi_lite_awready;
        w_hs_s    = wvalid_r && m_axi_lite_wready;
        ar_hs_s   = arvalid_r && m_axi_lite_arready;
        b_hs_s    = bready_r && m_axi_lite_bvalid;
        r_hs_s    = rready_r && m_axi_lite_rvalid;
        wr_done_s = (!awvalid_r || m_axi_lite_awready) && (!wvalid_r || m_axi_lite_wready);
    end

    // Next-state decode for the single-outstanding transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = cmd_write ? WR_AW_W : RD_AR;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_AW_W: begin
                if (wr_done_s) begin
                    state_s = WR_B;
                end else begin
                    state_s = WR_AW_W;
                end
            end
            WR_B: begin
                if (b_hs_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WR_B;
                end
            end
            RD_AR: begin
                if (ar_hs_s) begin
                    state_s = RD_R;
                end else begin
                    state_s = RD_AR;
                end
            end
            RD_R: begin
                if (r_hs_s) begin
                    state_s = RESP;
                end else begin
                    state_s = RD_R;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command capture: address and data stay fixed for the whole transaction.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            awaddr_r <= {ADDR_WIDTH{1'b0}};
            araddr_r <= {ADDR_WIDTH{1'b0}};
            wdata_r  <= {DATA_WIDTH{1'b0}};
        end else if (accept_s && cmd_write) begin
            awaddr_r <= cmd_addr;
            wdata_r  <= cmd_wdata;
        end else if (accept_s) begin
            araddr_r <= cmd_addr;
        end
    end

    // Address/data valids: raised on command accept, each dropped only after its own ready.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            arvalid_r <= 1'b0;
        end else begin
            if (accept_s && cmd_write) begin
                awvalid_r <= 1'b1;
            end else if (aw_hs_s) begin
                awvalid_r <= 1'b0;
            end
            if (accept_s && cmd_write) begin
                wvalid_r <= 1'b1;
            end else if (w_hs_s) begin
                wvalid_r <= 1'b0;
            end
            if (accept_s && !cmd_write) begin
                arvalid_r <= 1'b1;
            end else if (ar_hs_s) begin
                arvalid_r <= 1'b0;
            end
        end
    end

    // Response-channel readies and rsp_valid follow the state being entered.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            bready_r    <= (state_s == WR_B);
            rready_r    <= (state_s == RD_R);
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Response capture; read data reads back as zero after a write.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
            rsp_err_r   <= 1'b0;
        end else if (b_hs_s) begin
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= m_axi_lite_bresp;
            rsp_err_r   <= (m_axi_lite_bresp != 2'b00);
        end else if (r_hs_s) begin
            rsp_rdata_r <= m_axi_lite_rdata;
            rsp_resp_r  <= m_axi_lite_rresp;
            rsp_err_r   <= (m_axi_lite_rresp != 2'b00);
        end
    end

    assign cmd_ready          = (state_r == IDLE);
    assign rsp_valid          = rsp_valid_r;
    assign rsp_rdata          = rsp_rdata_r;
    assign rsp_resp           = rsp_resp_r;
    assign rsp_err            = rsp_err_r;
    assign m_axi_lite_awaddr  = awaddr_r;
    assign m_axi_lite_awvalid = awvalid_r;
    assign m_axi_lite_wdata   = wdata_r;
    assign m_axi_lite_wvalid  = wvalid_r;
    assign m_axi_lite_bready  = bready_r;
    assign m_axi_lite_araddr  = araddr_r;
    assign m_axi_lite_arvalid = arvalid_r;
    assign m_axi_lite_rready  = rready_r;

endmodule
